// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported, synchronous-read instruction memory
// between the CPU fetch port (read-only) and the program-loader port (read/write).
// Ties are broken round-robin. Each access takes IDLE -> ISSUE -> WAIT -> DONE,
// so an ack arrives three cycles after the request is sampled in IDLE.
// Optional build macro IMEM_MISALIGN_TRAP_EN: a request with addr[1:0] != 0 is
// answered with ack + err one cycle after it is granted, and never reaches memory.
module imem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ack,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic [31:0]       l_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       fetch_stall_cnt
);

`ifdef IMEM_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
`endif

    state_t            state, state_n;
    logic              gnt_l;      // granted port of the access in flight: 1 = loader
    logic              gnt_we;     // access in flight is a loader write
    logic              last_l;     // most recent grant went to the loader
    logic              sel_l;      // port chosen in IDLE this cycle
    logic              sel_we;
    logic [ADDR_W-1:0] sel_idx;
`ifdef IMEM_MISALIGN_TRAP_EN
    logic [1:0]        sel_lo;
`endif

    // Byte-address bits outside the word index are deliberately ignored, which
    // makes addresses wrap modulo the memory size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2],
                                f_addr[1:0], l_addr[1:0]};

    // Round-robin choice: on a tie the port that did not win last time goes.
    always_comb begin
        sel_l   = l_req && (!f_req || !last_l);
        sel_we  = sel_l && l_we;
        sel_idx = sel_l ? l_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];
`ifdef IMEM_MISALIGN_TRAP_EN
        sel_lo  = sel_l ? l_addr[1:0] : f_addr[1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; the sequence never depends on req after the grant, so a
    // dropped request still returns to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (f_req || l_req) begin
`ifdef IMEM_MISALIGN_TRAP_EN
                    state_n = (sel_lo != 2'b00) ? ERR : ISSUE;
`else
                    state_n = ISSUE;
`endif
                end
            end
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = DONE;
            DONE:    state_n = IDLE;
`ifdef IMEM_MISALIGN_TRAP_EN
            ERR:     state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs: memory strobe in ISSUE, read-data capture and ack
    // launch in WAIT so the ack is high during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_l     <= 1'b0;
            gnt_we    <= 1'b0;
            last_l    <= 1'b1;
            f_ack     <= 1'b0;
            l_ack     <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            l_rdata   <= '0;
        end else begin
            f_ack  <= 1'b0;
            l_ack  <= 1'b0;
            err    <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_req || l_req) begin
                        gnt_l  <= sel_l;
                        gnt_we <= sel_we;
                        last_l <= sel_l;
`ifdef IMEM_MISALIGN_TRAP_EN
                        if (sel_lo != 2'b00) begin
                            f_ack <= !sel_l;
                            l_ack <= sel_l;
                            err   <= 1'b1;
                        end else
`endif
                        begin
                            mem_en   <= 1'b1;
                            mem_we   <= sel_we;
                            mem_addr <= sel_idx;
                            if (sel_we) mem_wdata <= l_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (!gnt_l)       f_rdata <= mem_rdata;
                    else if (!gnt_we) l_rdata <= mem_rdata;
                    f_ack <= !gnt_l;
                    l_ack <= gnt_l;
                end
                default: ;
            endcase
        end
    end

    // Saturating count of cycles the fetch port spent waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_stall_cnt <= '0;
        else if (f_req && !f_ack && fetch_stall_cnt != 16'hFFFF)
            fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed accesses against a behavioural
// synchronous-read memory; expected acks are queued at issue time and a
// separate monitor pops and compares them whenever an ack appears.
module tb_imem_arbiter;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_ack;
    logic [31:0]       f_rdata;
    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_ack;
    logic [31:0]       l_rdata;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [15:0]       fetch_stall_cnt;

    imem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_stall_cnt(fetch_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;   // 1 = loader
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Synchronous-read memory: data for an access appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (f_ack || l_ack)) begin
            if (f_ack && l_ack) begin
                n_checks++; n_fail++;
                $display("FAIL both_acks: got f_ack=1 l_ack=1, expected one ack");
            end else if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ack: got f_ack=%0b l_ack=%0b, expected none", f_ack, l_ack);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", {31'b0, l_ack}, {31'b0, mon_e.port});
                check("ack_data", l_ack ? l_rdata : f_rdata, mon_e.data);
                check("ack_err",  {31'b0, err},   {31'b0, mon_e.err});
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_f_ack"},     f_ack,           0);
        check({tag, "_l_ack"},     l_ack,           0);
        check({tag, "_err"},       err,             0);
        check({tag, "_mem_en"},    mem_en,          0);
        check({tag, "_mem_we"},    mem_we,          0);
        check({tag, "_mem_addr"},  mem_addr,        0);
        check({tag, "_mem_wdata"}, mem_wdata,       0);
        check({tag, "_f_rdata"},   f_rdata,         0);
        check({tag, "_l_rdata"},   l_rdata,         0);
        check({tag, "_stall_cnt"}, fetch_stall_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        repeat (2) @(negedge clk);
        check_reset(tag);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One complete access, started at a negedge while the DUT is idle.
    task automatic access(input string tag, input logic port, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] idx, input logic [31:0] exp_data);
        int lat;
        exp_q.push_back('{port, exp_data, 1'b0});
        if (port) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
        else begin f_req = 1'b1; f_addr = addr; end
        @(negedge clk);
        check({tag, "_mem_en"},   mem_en,   1);
        check({tag, "_mem_addr"}, mem_addr, idx);
        check({tag, "_mem_we"},   mem_we,   {31'b0, we});
        if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
        lat = 1;
        while (!(f_ack || l_ack) && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no end of test, expected $finish before 20000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_cyc[4];
        int n_ack;
        int cyc;
        rst = 1'b1; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
        l_addr = '0; l_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hDEAD_0000 | i;
        mem[1] = 32'h5A5A_0001;
        mem[2] = 32'h1020_0004;

        do_reset("por");

        // Fetch only, then stall count covers cycles 0..2.
        access("fetch8", 1'b0, 1'b0, 32'h8, 32'h0, 2, 32'h1020_0004);
        check("stall_cnt_a", fetch_stall_cnt, 3);

        // Loader write leaves l_rdata at 0; fetch reads the written word back.
        access("lwrite",  1'b1, 1'b1, 32'h1C, 32'hAC05_07D0, 7, 32'h0);
        access("fetch1c", 1'b0, 1'b0, 32'h1C, 32'h0, 7, 32'hAC05_07D0);
        check("stall_cnt_b", fetch_stall_cnt, 6);
        access("lread",   1'b1, 1'b0, 32'h8, 32'h0, 2, 32'h1020_0004);

        // Upper address bits wrap.
        access("wrap", 1'b0, 1'b0, 32'h0000_1004, 32'h0, 1, 32'h5A5A_0001);

        // Misaligned fetch.
`ifdef IMEM_MISALIGN_TRAP_EN
        exp_q.push_back('{1'b0, 32'h5A5A_0001, 1'b1});
        f_req = 1'b1; f_addr = 32'h6;
        @(negedge clk);
        check("mis_f_ack",  f_ack,  1);
        check("mis_err",    err,    1);
        check("mis_mem_en", mem_en, 0);
        f_req = 1'b0;
        @(negedge clk);
        check("mis_mem_en2", mem_en, 0);
        check("mis_err2",    err,    0);
        @(negedge clk);
`else
        access("misalign", 1'b0, 1'b0, 32'h6, 32'h0, 1, 32'h5A5A_0001);
`endif

        // Tie after reset: f, l, f, l with acks 4 cycles apart.
        do_reset("tie_rst");
        exp_q.push_back('{1'b0, 32'h5A5A_0001, 1'b0});
        exp_q.push_back('{1'b1, 32'h1020_0004, 1'b0});
        exp_q.push_back('{1'b0, 32'h5A5A_0001, 1'b0});
        exp_q.push_back('{1'b1, 32'h1020_0004, 1'b0});
        f_addr = 32'h4; l_addr = 32'h8; l_we = 1'b0;
        f_req = 1'b1; l_req = 1'b1;
        n_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (f_ack || l_ack) begin
                check("tie_order", {31'b0, l_ack}, n_ack % 2);
                ack_cyc[n_ack] = cyc;
                n_ack++;
            end
        end
        f_req = 1'b0; l_req = 1'b0;
        check("tie_count", n_ack, 4);
        check("tie_first", ack_cyc[0], 3);
        for (int k = 1; k < 4; k++) check("tie_spacing", ack_cyc[k] - ack_cyc[k-1], 4);
        repeat (2) @(negedge clk);

        // Reset during WAIT abandons the fetch; the reissue completes normally.
        f_req = 1'b1; f_addr = 32'h8;
        repeat (2) @(negedge clk);
        rst = 1'b1; f_req = 1'b0;
        #1;
        check_reset("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        access("reissue", 1'b0, 1'b0, 32'h8, 32'h0, 2, 32'h1020_0004);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for the single-ported, synchronous-read instruction memory. It shares the memory between two requesters:

- the CPU fetch port (read-only);
- the program-loader port (read/write), which fills and inspects memory before and during execution.

Simultaneous requests are resolved round-robin. The block converts byte addresses to word indices and returns read data registered, with a one-cycle ack pulse.

## Interface
- `ADDR_W`, default 10: word-index width; memory depth is 2^ADDR_W words (1024).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `f_req`  in  1: fetch request; held high until `f_ack`.
- `f_addr`  in  32: fetch byte address; held stable with `f_req`.
- `f_ack`  out  1: one-cycle pulse; `f_rdata` valid.
- `f_rdata`  out  32: fetched instruction word.
- `l_req`  in  1: loader request; held high until `l_ack`.
- `l_we`  in  1: loader write (1) or read (0); held stable with `l_req`.
- `l_addr`  in  32: loader byte address.
- `l_wdata`  in  32: loader write data.
- `l_ack`  out  1: one-cycle pulse; for reads, `l_rdata` valid.
- `l_rdata`  out  32: loader read data.
- `err`  out  1: one-cycle pulse coincident with an ack for a rejected access; see Configuration.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: word index.
- `mem_wdata`  out  32: write data to memory.
- `mem_rdata`  in  32: memory read data, valid the cycle after `mem_en`.
- `fetch_stall_cnt`  out  16: saturating count of cycles `f_req` waited.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, plus ERR when the macro is defined.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it and go to ISSUE.
  - Both requests: grant the port not recorded in `last_grant`, then update `last_grant`.
  - `last_grant` resets to loader, so fetch wins the first tie.
- **ISSUE**: `mem_en` = 1, `mem_addr` = granted `addr[ADDR_W+1:2]`; all outputs are registered.
  - For a loader write: `mem_we` = 1 and `mem_wdata` = `l_wdata`.
  - Otherwise `mem_we` = 0.
  - Next state: WAIT.
- **WAIT**: `mem_en` = 0; capture `mem_rdata` into the granted port's rdata register. Next state: DONE.
- **DONE**: pulse the granted port's ack.
  - For writes, `l_rdata` is unchanged.
  - Next state: IDLE.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- `f_rdata` and `l_rdata` hold their last values between acks.
- A requester holding `req` high in the cycle after its ack has issued a new request.
- `fetch_stall_cnt`: +1 on every cycle `f_req` = 1 and `f_ack` = 0. It saturates at 0xFFFF and is cleared only by `rst`.

## Timing
- Latency: `req` sampled high in IDLE at cycle 0 gives ISSUE in cycle 1, WAIT in cycle 2, and ack in cycle 3.
- Throughput: at most one access per 4 cycles.
- With both ports requesting continuously, grants alternate: fetch, loader, fetch, and so on.
- A request arriving while another is in flight waits; it is sampled at the next IDLE.
- Reset values: state = IDLE, `f_ack` = `l_ack` = `err` = 0, `mem_en` = `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `f_rdata` = `l_rdata` = 0, `fetch_stall_cnt` = 0, `last_grant` = loader.
- Reset mid-transaction: the access is abandoned and no ack is issued. A write in ISSUE may or may not have landed. Requesters reissue after reset.
- `req` dropped before ack violates the protocol; behaviour is undefined, but the FSM still returns to IDLE within 3 cycles.

## Configuration
- `IMEM_MISALIGN_TRAP_EN` defined:
  - In IDLE, a granted request with `addr[1:0]` ≠ 0 goes to ERR instead of ISSUE. No `mem_en` or `mem_we` is asserted.
  - ERR pulses the port's ack and `err` together in cycle 1, leaves that port's rdata unchanged, then returns to IDLE.
- Undefined: `addr[1:0]` is ignored, the access proceeds normally, and `err` is tied to 0.

## Test plan
- Fetch only: `f_addr` = 0x8 with memory word 2 = 0x1020_0004 → `mem_en` in cycle 1 with `mem_addr` = 2; `f_ack` and `f_rdata` = 0x1020_0004 in cycle 3; `fetch_stall_cnt` = 3.
- Loader write then fetch: `l_we` = 1, `l_addr` = 0x1C, `l_wdata` = 0xAC05_07D0 → `mem_we` = 1 with `mem_addr` = 7 in cycle 1 and `l_ack` in cycle 3. A subsequent fetch of 0x1C returns 0xAC05_07D0.
- Tie after reset: `f_req` and `l_req` both high continuously → ack order is f, l, f, l, with acks 4 cycles apart.
- Wrap: `f_addr` = 0x0000_1004 with ADDR_W = 10 → `mem_addr` = 1.
- Misaligned, with `IMEM_MISALIGN_TRAP_EN`: `f_addr` = 0x6 → `f_ack` = `err` = 1 in cycle 1, no `mem_en`, `f_rdata` unchanged. Without the macro: `mem_addr` = 1 and `err` = 0.
- Reset in WAIT: assert `rst` in cycle 2 of a fetch → no `f_ack`, all outputs at reset values. A reissued fetch completes in 3 cycles.
